// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and the round-robin search used by the FIFO write-port arbiter.
// The search is written for the largest supported requester count and trimmed by callers.
package fifo_arb_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_ID_W  = 3;
  localparam int DEF_N_REQ = 4;
  localparam int ID_W      = $clog2(DEF_N_REQ);

  typedef enum logic {IDLE, OWN} arb_state_e;

  typedef struct packed {
    logic                found;
    logic [MAX_ID_W-1:0] idx;
  } rr_pick_t;

  // Walks k = n..1 so the smallest offset from last (highest priority) is written last.
  // The wrap is a subtract rather than a mask so non-power-of-two counts stay in range.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0]  valid,
                                       input logic [MAX_ID_W-1:0] last,
                                       input int                  n);
    rr_pick_t            r;
    int                  cand;
    logic [MAX_ID_W-1:0] ci;
    r.found = 1'b0;
    r.idx   = '0;
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= n) begin
        cand = int'(last) + k;
        if (cand >= n) cand = cand - n;
        ci = MAX_ID_W'(cand);
        if (valid[ci]) begin
          r.found = 1'b1;
          r.idx   = ci;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side signals of the arbiter, bundled with master/slave views.
// Handshake: a requester beat transfers in a cycle where req_valid[i] & req_ready[i] at the
// rising edge; req_valid may not depend on req_ready, and req_ready is at most one-hot.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ*FIFO_WIDTH-1:0] req_data;
  logic [N_REQ-1:0]            req_ready;
  logic                        fifo_wr_en;
  logic [FIFO_WIDTH-1:0]       fifo_data_in;
  logic                        fifo_full;
  logic                        fifo_almostfull;
  logic                        fifo_wr_ack;
  logic                        fifo_overflow;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    output req_ready, fifo_wr_en, fifo_data_in
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_almostfull, fifo_wr_ack, fifo_overflow,
    input  req_ready, fifo_wr_en, fifo_data_in
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_core.sv
// Combinational round-robin pick: first valid requester after `last`, wrapping at N_REQ.
module rr_arbiter_core
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [IW-1:0]    last,
  output logic             found,
  output logic [IW-1:0]    grant
);

  logic [MAX_REQ-1:0]  valid_ext;
  logic [MAX_ID_W-1:0] last_ext;
  rr_pick_t            pick;

  always_comb begin
    valid_ext = MAX_REQ'(valid);
    last_ext  = MAX_ID_W'(last);
    pick      = rr_pick(valid_ext, last_ext, N_REQ);
    found     = pick.found;
    grant     = IW'(pick.idx);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-limited sharing of one FIFO write port with registered write outputs,
// full/almost-full throttling and sticky wr_ack / overflow protocol checkers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int MAX_BURST  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  fifo_wr_arbiter_if.master        bus,
  output logic [$clog2(N_REQ)-1:0] owner_id,
  output logic                     busy,
  output logic                     ack_err,
  output logic                     ovf_err
);

  localparam int IW   = $clog2(N_REQ);
  localparam int BC_W = $clog2(MAX_BURST + 1);

  arb_state_e            state, state_n;
  logic [BC_W-1:0]       beat_cnt, beat_n;
  logic [IW-1:0]         owner_q, owner_n;
  logic [IW-1:0]         rr_last, rr_n;
  logic [IW-1:0]         acc_idx;
  logic [IW-1:0]         win;
  logic                  win_found;
  logic                  can_accept;
  logic                  arb_needed;
  logic                  accept;
  logic [N_REQ-1:0]      ready_n;
  logic [FIFO_WIDTH-1:0] sel_data;
  logic                  wr_en_q;
  logic [FIFO_WIDTH-1:0] data_q;
  logic                  wr_en_d;
  logic                  ack_err_q;
  logic                  ovf_err_q;

  rr_arbiter_core #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .valid (bus.req_valid),
    .last  (rr_last),
    .found (win_found),
    .grant (win)
  );

  // The registered write still in flight counts against almost-full; without one, the
  // last free slot may be taken.
  assign can_accept = en & ~bus.fifo_full & ~(wr_en_q & bus.fifo_almostfull);
  assign arb_needed = (state == IDLE) || !bus.req_valid[owner_q] ||
                      (beat_cnt == BC_W'(MAX_BURST));

  always_comb begin
    state_n = state;
    beat_n  = beat_cnt;
    owner_n = owner_q;
    rr_n    = rr_last;
    ready_n = '0;
    accept  = 1'b0;
    acc_idx = owner_q;
    if (!en) begin
      state_n = IDLE;
    end else if (arb_needed) begin
      if (win_found && can_accept) begin
        ready_n[win] = 1'b1;
        accept       = 1'b1;
        acc_idx      = win;
        owner_n      = win;
        rr_n         = win;
        beat_n       = BC_W'(1);
        state_n      = OWN;
      end else begin
        state_n = IDLE;
      end
    end else if (can_accept) begin
      ready_n[owner_q] = 1'b1;
      accept           = 1'b1;
      beat_n           = beat_cnt + 1'b1;
    end
  end

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (acc_idx == IW'(i)) sel_data = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt  <= '0;
      owner_q   <= '0;
      rr_last   <= IW'(N_REQ - 1);
      wr_en_q   <= 1'b0;
      data_q    <= '0;
      wr_en_d   <= 1'b0;
      ack_err_q <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      beat_cnt <= beat_n;
      owner_q  <= owner_n;
      rr_last  <= rr_n;
      wr_en_q  <= accept;
      if (accept) data_q <= sel_data;
      // The FIFO acknowledges one cycle after it sees the strobe.
      wr_en_d  <= wr_en_q;
      if (bus.fifo_wr_ack != wr_en_d) ack_err_q <= 1'b1;
      if (bus.fifo_overflow)          ovf_err_q <= 1'b1;
    end
  end

  assign bus.req_ready    = ready_n;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign owner_id         = owner_q;
  assign busy             = (state == OWN);
  assign ack_err          = ack_err_q;
  assign ovf_err          = ovf_err_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: a vector table for rotation/handshake behaviour plus
// hand-written multi-cycle sequences around a depth-8 FIFO model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int MB = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] owner_id;
  logic       busy;
  logic       ack_err;
  logic       ovf_err;

  fifo_wr_arbiter_if #(.N_REQ(N), .FIFO_WIDTH(W)) bus ();

  fifo_wr_arbiter #(.N_REQ(N), .FIFO_WIDTH(W), .MAX_BURST(MB)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .bus      (bus),
    .owner_id (owner_id),
    .busy     (busy),
    .ack_err  (ack_err),
    .ovf_err  (ovf_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- FIFO model (depth 8, no reads unless drain) ----------------
  int   fcount;
  logic drain, force_full, ack_kill, inject_ovf;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fcount            <= 0;
      bus.fifo_wr_ack   <= 1'b0;
      bus.fifo_overflow <= 1'b0;
    end else begin
      bus.fifo_wr_ack   <= bus.fifo_wr_en && (fcount < 8) && !ack_kill;
      bus.fifo_overflow <= (bus.fifo_wr_en && (fcount >= 8)) || inject_ovf;
      if (bus.fifo_wr_en && (fcount < 8) && !drain) fcount <= fcount + 1;
    end
  end

  assign bus.fifo_full       = force_full || (fcount == 8);
  assign bus.fifo_almostfull = (fcount == 7);

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] word_of(input int i, input int s);
    return W'((i + 1) * 4096 + s);
  endfunction

  function automatic int idx_of(input logic [N-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < N; i++) if (oh[i]) r = i;
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_data(input int s);
    for (int i = 0; i < N; i++) bus.req_data[i*W +: W] = word_of(i, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic [3:0] valid;
    logic [3:0] exp_ready;
    logic [1:0] exp_owner;
    logic       exp_busy;
  } vec_t;

  localparam int NV = 23;
  vec_t tbl[NV];

  int writes;
  int af_drops;
  int ovf_seen;
  logic [W-1:0] exp_w;

  initial begin
    rst = 1'b1; en = 1'b0; bus.req_valid = '0; bus.req_data = '0;
    drain = 1'b1; force_full = 1'b0; ack_kill = 1'b0; inject_ovf = 1'b0;

    // Four requesters always valid rotate in bursts of MB, then a few handshake cases.
    for (int s = 0; s < 17; s++)
      tbl[s] = '{1'b1, 4'b1111, 4'(1 << ((s / MB) % N)), 2'((s / MB) % N), 1'b1};
    tbl[17] = '{1'b0, 4'b1111, 4'b0000, 2'd0, 1'b0};
    tbl[18] = '{1'b1, 4'b0100, 4'b0100, 2'd2, 1'b1};
    tbl[19] = '{1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0};
    tbl[20] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[21] = '{1'b1, 4'b1001, 4'b1000, 2'd3, 1'b1};
    tbl[22] = '{1'b1, 4'b0001, 4'b0001, 2'd0, 1'b1};

    @(negedge clk); @(negedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("rst_data", 32'(bus.fifo_data_in), 0);
    chk("rst_owner", 32'(owner_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {30'd0, ack_err, ovf_err}, 0);
    @(negedge clk);
    rst = 1'b0;

    // ---- table ----
    for (int v = 0; v < NV; v++) begin
      en = tbl[v].en;
      bus.req_valid = tbl[v].valid;
      set_data(v);
      #1;
      chk($sformatf("tbl%0d_ready", v), 32'(bus.req_ready), 32'(tbl[v].exp_ready));
      if (tbl[v].exp_ready != 0) exp_q.push_back(word_of(idx_of(tbl[v].exp_ready), v));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_wr_en", v), 32'(bus.fifo_wr_en), 32'(tbl[v].exp_ready != 0));
      if (tbl[v].exp_ready != 0 && exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk($sformatf("tbl%0d_data", v), 32'(bus.fifo_data_in), 32'(exp_w));
      end
      chk($sformatf("tbl%0d_owner", v), 32'(owner_id), 32'(tbl[v].exp_owner));
      chk($sformatf("tbl%0d_busy", v), 32'(busy), 32'(tbl[v].exp_busy));
      @(negedge clk);
    end
    chk("tbl_ack_err", 32'(ack_err), 0);
    chk("tbl_ovf_err", 32'(ovf_err), 0);

    // ---- sole requester 2: no bubble across forced re-arbitration ----
    bus.req_valid = '0;
    do_reset();
    en = 1'b1;
    bus.req_valid = 4'b0100;
    for (int b = 0; b < 10; b++) begin
      set_data(100 + b);
      #1;
      chk($sformatf("solo%0d_ready", b), 32'(bus.req_ready), 32'b0100);
      @(posedge clk); #1;
      chk($sformatf("solo%0d_wr_en", b), 32'(bus.fifo_wr_en), 1);
      chk($sformatf("solo%0d_data", b), 32'(bus.fifo_data_in), 32'(word_of(2, 100 + b)));
      @(negedge clk);
    end
    bus.req_valid = '0;

    // ---- depth-8 FIFO, no reads, requester 1 streaming ----
    do_reset();
    drain = 1'b0;
    writes = 0; af_drops = 0; ovf_seen = 0;
    bus.req_valid = 4'b0010;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (bus.fifo_almostfull && bus.fifo_wr_en) begin
        af_drops++;
        chk("af_inflight_ready", 32'(bus.req_ready), 0);
      end
      @(posedge clk); #1;
      if (bus.fifo_wr_en) writes++;
      if (bus.fifo_overflow) ovf_seen++;
      @(negedge clk);
    end
    chk("fill_writes", 32'(writes), 8);
    chk("fill_af_seen", 32'(af_drops), 1);
    chk("fill_count", 32'(fcount), 8);
    chk("fill_ovf_seen", 32'(ovf_seen), 0);
    chk("fill_ovf_err", 32'(ovf_err), 0);
    chk("fill_ack_err", 32'(ack_err), 0);
    bus.req_valid = '0;

    // ---- stall mid-burst: requester 3 at beat 2, full for 5 cycles ----
    do_reset();
    drain = 1'b1;
    bus.req_valid = 4'b1000;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk($sformatf("stall_pre%0d_ready", b), 32'(bus.req_ready), 32'b1000);
      @(negedge clk);
    end
    bus.req_valid = 4'b1100;
    force_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("stall%0d_ready", c), 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("stall%0d_busy", c), 32'(busy), 1);
      chk($sformatf("stall%0d_owner", c), 32'(owner_id), 3);
      @(negedge clk);
    end
    force_full = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1;
      chk($sformatf("stall_post%0d_ready", b), 32'(bus.req_ready), 32'b1000);
      @(negedge clk);
    end
    #1;
    chk("stall_rotate_ready", 32'(bus.req_ready), 32'b0100);
    @(posedge clk); #1;
    chk("stall_rotate_owner", 32'(owner_id), 2);
    @(negedge clk);

    // ---- missing wr_ack, then overflow pulse; errors are sticky ----
    chk("pre_inj_ack_err", 32'(ack_err), 0);
    ack_kill = 1'b1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    ack_kill = 1'b0;
    #1;
    chk("inj_ack_err", 32'(ack_err), 1);
    chk("inj_ovf_err_clear", 32'(ovf_err), 0);
    @(negedge clk);
    inject_ovf = 1'b1;
    @(negedge clk);
    inject_ovf = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("inj_ovf_err", 32'(ovf_err), 1);

    en = 1'b0;
    bus.req_valid = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("dis%0d_ready", c), 32'(bus.req_ready), 0);
      @(posedge clk); #1;
      chk($sformatf("dis%0d_busy", c), 32'(busy), 0);
      @(negedge clk);
    end
    chk("sticky_ack_err", 32'(ack_err), 1);
    chk("sticky_ovf_err", 32'(ovf_err), 1);
    en = 1'b1;
    bus.req_valid = '0;
    do_reset();
    #1;
    chk("clr_errs", {30'd0, ack_err, ovf_err}, 0);
    @(negedge clk);

    // ---- reset in the third cycle of a burst owned by requester 2 ----
    bus.req_valid = 4'b0100;
    set_data(200);
    @(negedge clk);
    bus.req_valid = 4'b1111;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("midrst_data", 32'(bus.fifo_data_in), 0);
    chk("midrst_owner", 32'(owner_id), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_first_ready", 32'(bus.req_ready), 32'b0001);
    @(posedge clk); #1;
    chk("midrst_first_owner", 32'(owner_id), 0);
    chk("midrst_first_data", 32'(bus.fifo_data_in), 32'(word_of(0, 200)));

    // ---- report ----
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Shares the write port of one synchronous FIFO among N_REQ producers. Uses round-robin arbitration with bounded burst locking. Registers the FIFO write strobe and data, and throttles on full/almostfull so the FIFO never sees a write while full. It also checks the FIFO's wr_ack/overflow responses and flags protocol errors for the verification bench.

Parameters:
N_REQ, 4, number of requesters (2..8)
FIFO_WIDTH, 16, data word width
MAX_BURST, 4, max consecutive beats granted to one owner before forced re-arbitration (1..15)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  arbiter enable; 0 = accept nothing
req_valid  in  N_REQ  per-requester word valid
req_data  in  N_REQ*FIFO_WIDTH  requester i data at bits [i*FIFO_WIDTH +: FIFO_WIDTH]
req_ready  out  N_REQ  one-hot (or zero) combinational accept; a beat transfers when valid&ready
fifo_wr_en  out  1  registered FIFO write strobe
fifo_data_in  out  FIFO_WIDTH  registered FIFO write data
fifo_full  in  1  FIFO full
fifo_almostfull  in  1  FIFO count == depth-1
fifo_wr_ack  in  1  FIFO write acknowledge (one cycle after an accepted write)
fifo_overflow  in  1  FIFO overflow indication
owner_id  out  $clog2(N_REQ)  current/last owner
busy  out  1  state == OWN
ack_err  out  1  sticky: wr_ack mismatch
ovf_err  out  1  sticky: fifo_overflow seen

Behaviour:
- Reset (async, rst=1): fifo_wr_en=0, fifo_data_in=0, owner_id=0, busy=0, ack_err=0, ovf_err=0, state=IDLE, beat_cnt=0, rr_last=N_REQ-1 (first search starts at requester 0).
- can_accept = en & !fifo_full & !(fifo_wr_en & fifo_almostfull). This covers a write in flight one cycle behind; a FIFO that is exactly almost full with no write in flight may accept.
- Latency: a beat accepted at edge t is driven as fifo_wr_en=1 with its data during cycle t+1. fifo_wr_en=0 in any cycle after a non-accepting edge.
- FSM states: IDLE and OWN.
- Arbitration:
  - Runs in IDLE, or in OWN when the owner drops req_valid or beat_cnt==MAX_BURST.
  - Winner = first i with req_valid[i], searching from rr_last+1 modulo N_REQ.
  - If can_accept: req_ready[winner]=1, owner_id<=winner, rr_last<=winner, beat_cnt<=1, state<=OWN.
  - If no valid requester or !can_accept: no accept; state<=IDLE.
- OWN with req_valid[owner] and beat_cnt<MAX_BURST:
  - can_accept=1: req_ready[owner]=1, beat_cnt++.
  - can_accept=0 (stall): hold ownership and beat_cnt; no ready.
- A sole requester re-wins after a forced re-arbitration, starting a new burst. It is never starved of throughput.
- en=0: no ready; state<=IDLE at next edge; rr_last retained.
- At most one req_ready bit is high per cycle. req_ready never asserts while can_accept=0.
- Checks:
  - ack_err sets if fifo_wr_ack differs from fifo_wr_en delayed one cycle.
  - ovf_err sets on fifo_overflow.
  - Both sticky until rst.
- beat_cnt width $clog2(MAX_BURST+1). owner_id wraps modulo N_REQ, with non-power-of-2 N_REQ handled explicitly.

Decomposition:
- Package fifo_arb_pkg:
  - typedef arb_state_e {IDLE, OWN}
  - function rr_pick(valid, last) returning index + found flag
  - localparam ID_W = $clog2(N_REQ)
- Natural sub-module: rr_arbiter_core (combinational round-robin priority pick, parameterised N_REQ). The FSM, throttle, output registers and checkers stay in fifo_wr_arbiter.

Test Plan:
- Reset mid-burst: assert rst during cycle 3 of a burst -> all outputs 0 immediately; after release, first grant goes to requester 0 when all valid.
- All 4 requesters valid continuously, FIFO never full, MAX_BURST=4:
  - grants: req0 x4, req1 x4, req2 x4, req3 x4, req0...
  - fifo_data_in order matches the accepted beats one cycle later.
- Only req2 valid for 10 beats -> 10 consecutive accepts with a new burst every 4 beats; no bubble in fifo_wr_en.
- FIFO model depth 8, no reads, req1 streaming:
  - exactly 8 writes issued.
  - req_ready drops when almostfull coincides with a write in flight.
  - fifo_overflow never asserts.
  - ovf_err=0, ack_err=0.
- Stall mid-burst: owner req3 at beat 2, force fifo_full high for 5 cycles -> req3 keeps ownership, beat_cnt stays 2; 2 more beats on release, then rotation to the next valid requester.
- Inject a missing wr_ack after a write, then an overflow pulse -> ack_err=1 and ovf_err=1, held until rst; en=0 for 3 cycles -> no req_ready, busy=0.
